wb_hazard_ctrl: RTL

//  Sequences the write-back control path of the RV32I 5-stage pipeline. Carries each decoded

---
 rtl/rv32_ctrl_pkg.sv | 39 +++
 rtl/wb_ctrl_stage.sv | 33 +++
 rtl/wb_hazard_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared codes, stage record and hazard helpers for the write-back control path
package rv32_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int WB_SEL_W = 2;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   rd;
    logic                wer;
    logic [WB_SEL_W-1:0] wb_sel;
  } stage_t;

  // x0 is hardwired, so an instruction targeting it never counts as a producer
  function automatic logic writes_reg(input stage_t s);
    return s.valid & s.wer & (s.rd != '0);
  endfunction

  function automatic fwd_sel_e fwd_pick(input stage_t ex, input stage_t mem,
                                        input logic use_rs, input logic [REG_AW-1:0] rs);
    if (use_rs && writes_reg(ex) && ex.rd == rs) return FWD_MEM;
    if (use_rs && writes_reg(mem) && mem.rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/wb_ctrl_stage.sv
// rtl/wb_ctrl_stage.sv - one pipeline control stage register with hold and bubble insertion
module wb_ctrl_stage
  import rv32_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (!hold) begin
      stage_d = bubble ? '0 : d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/wb_hazard_ctrl.sv
// rtl/wb_hazard_ctrl.sv - EX/MEM/WB control sequencing, load-use stall, forwarding selects, retire count
module wb_hazard_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int RA_W  = REG_AW,
  parameter int WBS_W = WB_SEL_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wer,
  input  logic [WBS_W-1:0] id_wb_sel,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_flush,
  input  logic             ext_stall,
  output logic             stall_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WBS_W-1:0] wb_sel,
  output logic [CNT_W-1:0] instret
);

  stage_t     id_s;
  stage_t     ex_s;
  stage_t     mem_s;
  stage_t     wb_s;
  logic       load_use;
  logic       ex_accept;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  assign id_s = '{valid: id_valid, rd: id_rd, wer: id_wer, wb_sel: id_wb_sel};

  assign load_use = writes_reg(ex_s) && (ex_s.wb_sel == WB_MEM) &&
                    ((id_use_rs1 && id_rs1 == ex_s.rd) || (id_use_rs2 && id_rs2 == ex_s.rd));

  // A taken branch kills the ID op, so it must not also be held by a load-use stall
  assign ex_accept = id_valid & ~load_use & ~ex_flush;
  assign stall_id  = ext_stall | (load_use & ~ex_flush);

  wb_ctrl_stage u_ex  (.clk(clk), .rst_n(reset), .hold(ext_stall), .bubble(~ex_accept), .d(id_s),  .q(ex_s));
  wb_ctrl_stage u_mem (.clk(clk), .rst_n(reset), .hold(ext_stall), .bubble(1'b0),       .d(ex_s),  .q(mem_s));
  wb_ctrl_stage u_wb  (.clk(clk), .rst_n(reset), .hold(ext_stall), .bubble(1'b0),       .d(mem_s), .q(wb_s));

  always_comb begin
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    instret_d = instret_q;
    if (!ext_stall) begin
      fwd_a_d = ex_accept ? fwd_pick(ex_s, mem_s, id_use_rs1, id_rs1) : FWD_RF;
      fwd_b_d = ex_accept ? fwd_pick(ex_s, mem_s, id_use_rs2, id_rs2) : FWD_RF;
      if (wb_s.valid) begin
        instret_d = instret_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      instret_q <= '0;
    end else begin
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      instret_q <= instret_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign rf_we     = writes_reg(wb_s);
  assign rf_waddr  = wb_s.rd;
  assign wb_sel    = wb_s.wb_sel;
  assign instret   = instret_q;

endmodule
